// File: rtl/m_arith_pkg.sv
// m_arith_pkg: shared constants, helpers and stage records for the Mitchell multiplier pipeline.
// Records are sized for the widest legal operand; stages use only the low bits they need.
package m_arith_pkg;
    localparam int STAGES = 3;
    localparam int MAX_W  = 32;
    localparam int MAX_LW = 6;

    function automatic int log_w(input int size);
        return $clog2(size);
    endfunction

    function automatic logic [MAX_LW-1:0] lod(input logic [MAX_W-1:0] x);
        logic [MAX_LW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) if (x[i]) r = MAX_LW'(i);
        return r;
    endfunction

    typedef struct packed {
        logic              zero;
        logic [MAX_LW-1:0] k1;
        logic [MAX_LW-1:0] k2;
        logic [MAX_W-1:0]  f1;
        logic [MAX_W-1:0]  f2;
    } s12_t;

    typedef struct packed {
        logic              zero;
        logic [MAX_LW-1:0] k;
        logic [MAX_W-1:0]  fsum;
    } s23_t;
endpackage

// File: rtl/m_antilog.sv
// m_antilog: combinational Mitchell antilog, shifting the restored mantissa by the exponent sum.
module m_antilog #(
    parameter int SIZE = 16,
    parameter int LW   = m_arith_pkg::log_w(SIZE)
) (
    input  logic [LW:0]       k,
    input  logic [SIZE-1:0]   fsum,
    output logic [2*SIZE-1:0] res
);
    logic [SIZE-1:0]   mant;
    logic [LW:0]       e;
    logic [3*SIZE-1:0] wide;

    // On carry the sum already equals f1+f2 with weight-1 MSB; otherwise restore the implicit one.
    always_comb begin
        mant = fsum[SIZE-1] ? fsum : {1'b1, fsum[SIZE-2:0]};
        e    = k + (LW+1)'(fsum[SIZE-1]);
        wide = (3*SIZE)'(mant) << e;
        res  = (2*SIZE)'(wide >> (SIZE - 1));
    end
endmodule

// File: rtl/m_multiplier_pipe.sv
// m_multiplier_pipe: 3-stage valid/ready Mitchell approximate unsigned multiplier.
module m_multiplier_pipe
    import m_arith_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int truncation = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   X1,
    input  logic [SIZE-1:0]   X2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] res
);
    localparam int LW = log_w(SIZE);
    localparam logic [SIZE-2:0] F_MASK = {(SIZE-1){1'b1}} << (SIZE - 1 - truncation);

    logic              v1, v2, v3, rdy1, rdy2, rdy3;
    s12_t              s1_d, s1_q;
    s23_t              s2_d, s2_q;
    logic [LW-1:0]     k1, k2;
    logic [SIZE-1:0]   n1, n2;
    logic [LW:0]       ksum;
    logic [SIZE-1:0]   fsum;
    logic [2*SIZE-1:0] al_res, res_q;

    assign rdy3      = !v3 || out_ready;
    assign rdy2      = !v2 || rdy3;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;
    assign res       = res_q;

    // Normalising each operand puts its leading one at the MSB; the bits below are the fraction.
    always_comb begin
        k1 = LW'(lod(MAX_W'(X1)));
        k2 = LW'(lod(MAX_W'(X2)));
        n1 = X1 << (SIZE - 1 - int'(k1));
        n2 = X2 << (SIZE - 1 - int'(k2));
        s1_d      = '0;
        s1_d.zero = (X1 == '0) || (X2 == '0);
        s1_d.k1   = MAX_LW'(k1);
        s1_d.k2   = MAX_LW'(k2);
        s1_d.f1   = MAX_W'((SIZE-1)'(n1) & F_MASK);
        s1_d.f2   = MAX_W'((SIZE-1)'(n2) & F_MASK);
    end

    always_comb begin
        ksum      = (LW+1)'(s1_q.k1) + (LW+1)'(s1_q.k2);
        fsum      = SIZE'(s1_q.f1) + SIZE'(s1_q.f2);
        s2_d      = '0;
        s2_d.zero = s1_q.zero;
        s2_d.k    = MAX_LW'(ksum);
        s2_d.fsum = MAX_W'(fsum);
    end

    m_antilog #(.SIZE(SIZE), .LW(LW)) u_antilog (
        .k    ((LW+1)'(s2_q.k)),
        .fsum (SIZE'(s2_q.fsum)),
        .res  (al_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
        end else begin
            if (rdy1) v1 <= in_valid;
            if (rdy2) v2 <= v1;
            if (rdy3) v3 <= v2;
            if (rdy1 && in_valid) s1_q <= s1_d;
            if (rdy2 && v1) s2_q <= s2_d;
            if (rdy3 && v2) res_q <= s2_q.zero ? '0 : al_res;
        end
    end
endmodule
